id_stage_p: RTL and testbench

Parametrised, registered instruction-decode stage for the 5-stage MIPS-subset pipeline, sitting between the IF/ID register and EX. It decodes logic-immediate, LUI, R-type logic and shift instructions, and resolves operands from the regfile or from NUM_FWD prioritised forwarding sources. It detects load-use hazards and stalls upstream, then registers the result into an ID/EX output register with a valid/ready handshake and flush.

---
 rtl/id_stage_p.sv | 260 ++++++++++++++++++++++++++
 tb/tb_id_stage_p.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_p.sv
// Registered instruction-decode stage: decodes logic/shift ops, resolves operands
// through prioritised forwarding, stalls on load-use and drives an ID/EX register.
module id_stage_p #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid_i,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [NUM_FWD-1:0]      fwd_load_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                    ex_ready_i,
  input  logic                    flush_i,
  output logic                    reg1_read_o,
  output logic                    reg2_read_o,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  output logic                    id_ready_o,
  output logic                    valid_o,
  output logic [31:0]             pc_o,
  output logic [7:0]              aluop_o,
  output logic [2:0]              alusel_o,
  output logic [XLEN-1:0]         reg1_o,
  output logic [XLEN-1:0]         reg2_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic                    inst_invalid_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALU_AND = 8'b00100100;
  localparam logic [7:0] ALU_OR  = 8'b00100101;
  localparam logic [7:0] ALU_XOR = 8'b00100110;
  localparam logic [7:0] ALU_NOR = 8'b00100111;
  localparam logic [7:0] ALU_SLL = 8'b01111100;
  localparam logic [7:0] ALU_SRL = 8'b00000010;
  localparam logic [7:0] ALU_SRA = 8'b00000011;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010
  } alusel_e;

  typedef struct packed {
    logic            hit;
    logic            load;
    logic [XLEN-1:0] data;
  } fwd_t;

  logic [5:0]      op;
  logic [5:0]      funct;
  logic            dec_r1;
  logic            dec_r2;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_wd;
  logic            dec_wreg;
  logic [7:0]      dec_aluop;
  alusel_e         dec_alusel;
  logic            dec_invalid;

  fwd_t            f1;
  fwd_t            f2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hazard;
  logic            adv;

  assign op          = inst_i[31:26];
  assign funct       = inst_i[5:0];
  assign reg1_addr_o = inst_i[25:21];
  assign reg2_addr_o = inst_i[20:16];
  assign reg1_read_o = dec_r1;
  assign reg2_read_o = dec_r2;

  always_comb begin
    dec_r1      = 1'b0;
    dec_r2      = 1'b0;
    dec_imm     = '0;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    dec_aluop   = '0;
    dec_alusel  = SEL_NOP;
    dec_invalid = 1'b1;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        dec_r1      = 1'b1;
        dec_wd      = inst_i[20:16];
        dec_wreg    = 1'b1;
        dec_alusel  = SEL_LOGIC;
        dec_invalid = 1'b0;
        dec_imm     = XLEN'(inst_i[15:0]);
        case (op)
          OP_ANDI: dec_aluop = ALU_AND;
          OP_XORI: dec_aluop = ALU_XOR;
          OP_LUI: begin
            dec_aluop = ALU_OR;
            dec_imm   = XLEN'({inst_i[15:0], 16'h0000});
          end
          default: dec_aluop = ALU_OR;
        endcase
      end
      OP_SPECIAL: begin
        case (funct)
          FN_OR, FN_AND, FN_XOR, FN_NOR: begin
            dec_r1      = 1'b1;
            dec_r2      = 1'b1;
            dec_wd      = inst_i[15:11];
            dec_wreg    = 1'b1;
            dec_alusel  = SEL_LOGIC;
            dec_invalid = 1'b0;
            case (funct)
              FN_AND:  dec_aluop = ALU_AND;
              FN_XOR:  dec_aluop = ALU_XOR;
              FN_NOR:  dec_aluop = ALU_NOR;
              default: dec_aluop = ALU_OR;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_r2      = 1'b1;
            dec_imm     = XLEN'(inst_i[10:6]);
            dec_wd      = inst_i[15:11];
            dec_wreg    = 1'b1;
            dec_alusel  = SEL_SHIFT;
            dec_invalid = 1'b0;
            case (funct)
              FN_SRL:  dec_aluop = ALU_SRL;
              FN_SRA:  dec_aluop = ALU_SRA;
              default: dec_aluop = ALU_SLL;
            endcase
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Lowest index wins: once a source hits, later (older) sources are ignored.
  function automatic fwd_t fwd_pick(
    input logic [4:0]              addr,
    input logic [NUM_FWD-1:0]      wreg,
    input logic [NUM_FWD-1:0]      load,
    input logic [5*NUM_FWD-1:0]    wd,
    input logic [XLEN*NUM_FWD-1:0] wdata
  );
    fwd_t                    r;
    logic [NUM_FWD-1:0]      wreg_sh;
    logic [NUM_FWD-1:0]      load_sh;
    logic [5*NUM_FWD-1:0]    wd_sh;
    logic [XLEN*NUM_FWD-1:0] wdata_sh;
    r = '0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      wreg_sh  = wreg >> i;
      load_sh  = load >> i;
      wd_sh    = wd >> (5 * i);
      wdata_sh = wdata >> (XLEN * i);
      if (!r.hit && wreg_sh[0] && (wd_sh[4:0] == addr)) begin
        r.hit  = 1'b1;
        r.load = load_sh[0];
        r.data = wdata_sh[XLEN-1:0];
      end
    end
    return r;
  endfunction

  always_comb begin
    f1 = fwd_pick(reg1_addr_o, fwd_wreg_i, fwd_load_i, fwd_wd_i, fwd_wdata_i);
    f2 = fwd_pick(reg2_addr_o, fwd_wreg_i, fwd_load_i, fwd_wd_i, fwd_wdata_i);

    if (!dec_r1)                op1 = dec_imm;
    else if (reg1_addr_o == '0) op1 = '0;
    else if (f1.hit)            op1 = f1.data;
    else                        op1 = reg1_data_i;

    if (!dec_r2)                op2 = dec_imm;
    else if (reg2_addr_o == '0) op2 = '0;
    else if (f2.hit)            op2 = f2.data;
    else                        op2 = reg2_data_i;

    hazard = inst_valid_i &&
             ((dec_r1 && (reg1_addr_o != '0) && f1.hit && f1.load) ||
              (dec_r2 && (reg2_addr_o != '0) && f2.hit && f2.load));
  end

  assign adv        = !valid_o || ex_ready_i;
  assign id_ready_o = flush_i || (adv && !hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o        <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= '0;
      alusel_o       <= '0;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      valid_o        <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= '0;
      alusel_o       <= '0;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        valid_o  <= 1'b0;
        wreg_o   <= 1'b0;
        aluop_o  <= '0;
        alusel_o <= '0;
      end else begin
        valid_o        <= inst_valid_i;
        pc_o           <= pc_i;
        aluop_o        <= dec_aluop;
        alusel_o       <= dec_alusel;
        reg1_o         <= op1;
        reg2_o         <= op2;
        wd_o           <= dec_wd;
        wreg_o         <= dec_wreg && inst_valid_i;
        inst_invalid_o <= dec_invalid;
      end
    end
  end

  // Counts every hazard cycle, including ones where EX is also back-pressuring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (hazard && inst_valid_i && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p: decode, forwarding priority, load-use stalls,
// back-pressure, flush and reset behaviour against hand-computed values.
module tb_id_stage_p;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned CNT_W   = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    inst_valid;
  logic [31:0]             pc;
  logic [31:0]             inst;
  logic [XLEN-1:0]         reg1_data;
  logic [XLEN-1:0]         reg2_data;
  logic [NUM_FWD-1:0]      fwd_wreg;
  logic [NUM_FWD-1:0]      fwd_load;
  logic [5*NUM_FWD-1:0]    fwd_wd;
  logic [XLEN*NUM_FWD-1:0] fwd_wdata;
  logic                    ex_ready;
  logic                    flush;
  logic                    reg1_read;
  logic                    reg2_read;
  logic [4:0]              reg1_addr;
  logic [4:0]              reg2_addr;
  logic                    id_ready;
  logic                    valid;
  logic [31:0]             pc_q;
  logic [7:0]              aluop;
  logic [2:0]              alusel;
  logic [XLEN-1:0]         reg1;
  logic [XLEN-1:0]         reg2;
  logic [4:0]              wd;
  logic                    wreg;
  logic                    inst_invalid;
  logic [CNT_W-1:0]        stall_cnt;

  int total = 0;
  int bad   = 0;

  id_stage_p #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid_i   (inst_valid),
    .pc_i           (pc),
    .inst_i         (inst),
    .reg1_data_i    (reg1_data),
    .reg2_data_i    (reg2_data),
    .fwd_wreg_i     (fwd_wreg),
    .fwd_load_i     (fwd_load),
    .fwd_wd_i       (fwd_wd),
    .fwd_wdata_i    (fwd_wdata),
    .ex_ready_i     (ex_ready),
    .flush_i        (flush),
    .reg1_read_o    (reg1_read),
    .reg2_read_o    (reg2_read),
    .reg1_addr_o    (reg1_addr),
    .reg2_addr_o    (reg2_addr),
    .id_ready_o     (id_ready),
    .valid_o        (valid),
    .pc_o           (pc_q),
    .aluop_o        (aluop),
    .alusel_o       (alusel),
    .reg1_o         (reg1),
    .reg2_o         (reg2),
    .wd_o           (wd),
    .wreg_o         (wreg),
    .inst_invalid_o (inst_invalid),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    inst_valid = 1'b0; pc = '0; inst = '0; reg1_data = '0; reg2_data = '0;
    fwd_wreg = '0; fwd_load = '0; fwd_wd = '0; fwd_wdata = '0;
    ex_ready = 1'b1; flush = 1'b0;

    tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_pc", pc_q, 0);
    check("rst_wreg", wreg, 0);
    rst = 1'b1;

    // ORI $2,$1,0x00F0
    inst_valid = 1'b1; pc = 32'h100; inst = 32'h342200F0;
    reg1_data = 32'h00000F00; reg2_data = 32'h00001234;
    #1;
    check("ori_addr1", reg1_addr, 1);
    check("ori_rd1", reg1_read, 1);
    check("ori_rd2", reg2_read, 0);
    check("ori_ready", id_ready, 1);
    tick();
    check("ori_valid", valid, 1);
    check("ori_pc", pc_q, 32'h100);
    check("ori_aluop", aluop, 8'h25);
    check("ori_alusel", alusel, 3'b001);
    check("ori_reg1", reg1, 32'h00000F00);
    check("ori_reg2", reg2, 32'h000000F0);
    check("ori_wd", wd, 2);
    check("ori_wreg", wreg, 1);
    check("ori_inval", inst_invalid, 0);

    // OR $3,$1,$2: src0 -> $1, src1 -> $2
    pc = 32'h104; inst = 32'h00221825;
    reg1_data = 32'h0000DEAD; reg2_data = 32'h0000BEEF;
    fwd_wreg = 2'b11; fwd_load = 2'b00;
    fwd_wd = {5'd2, 5'd1}; fwd_wdata = {32'h00005555, 32'hAAAA0000};
    tick();
    check("or_reg1", reg1, 32'hAAAA0000);
    check("or_reg2", reg2, 32'h00005555);
    check("or_wd", wd, 3);
    check("or_aluop", aluop, 8'h25);

    // Both sources hit $1; younger wins, older load is shadowed
    pc = 32'h108;
    fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'h00001111, 32'hAAAA0000};
    fwd_load = 2'b10;
    #1;
    check("prio_ready", id_ready, 1);
    tick();
    check("prio_reg1", reg1, 32'hAAAA0000);
    check("prio_reg2", reg2, 32'h0000BEEF);
    check("prio_valid", valid, 1);

    // Load-use on $1 for 3 cycles
    pc = 32'h200; inst = 32'h342200F0; reg1_data = 32'h00000F00;
    fwd_wreg = 2'b01; fwd_load = 2'b01;
    fwd_wd = {5'd0, 5'd1}; fwd_wdata = {32'h0, 32'h0000CAFE};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lu_ready", id_ready, 0);
      tick();
      check("lu_bubble", valid, 0);
      check("lu_cnt", stall_cnt, 32'(i + 1));
    end
    fwd_wreg = 2'b00; fwd_load = 2'b00;
    #1;
    check("lu_ready4", id_ready, 1);
    tick();
    check("lu_valid4", valid, 1);
    check("lu_pc4", pc_q, 32'h200);
    check("lu_reg1", reg1, 32'h00000F00);
    check("lu_cnt4", stall_cnt, 3);

    // Back-pressure: XORI $5,$1,0xFFFF waits two cycles
    ex_ready = 1'b0; pc = 32'h300; inst = 32'h3825FFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_ready", id_ready, 0);
      tick();
      check("bp_pc", pc_q, 32'h200);
      check("bp_valid", valid, 1);
      check("bp_aluop", aluop, 8'h25);
      check("bp_reg2", reg2, 32'h000000F0);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_ready_rel", id_ready, 1);
    tick();
    check("xori_pc", pc_q, 32'h300);
    check("xori_aluop", aluop, 8'h26);
    check("xori_reg2", reg2, 32'h0000FFFF);
    check("xori_wd", wd, 5);

    // Flush while a hazard is present
    pc = 32'h400; inst = 32'h342200F0;
    fwd_wreg = 2'b01; fwd_load = 2'b01; fwd_wd = {5'd0, 5'd1};
    flush = 1'b1;
    #1;
    check("fl_ready", id_ready, 1);
    tick();
    check("fl_valid", valid, 0);
    check("fl_wreg", wreg, 0);
    check("fl_pc", pc_q, 0);
    check("fl_cnt", stall_cnt, 3);
    flush = 1'b0; fwd_wreg = 2'b00; fwd_load = 2'b00;

    // SLL $4,$5,3
    pc = 32'h500; inst = 32'h000520C0;
    reg1_data = 32'hFFFFFFFF; reg2_data = 32'h80000001;
    #1;
    check("sll_rd1", reg1_read, 0);
    check("sll_rd2", reg2_read, 1);
    check("sll_addr2", reg2_addr, 5);
    tick();
    check("sll_reg1", reg1, 3);
    check("sll_reg2", reg2, 32'h80000001);
    check("sll_alusel", alusel, 3'b010);
    check("sll_aluop", aluop, 8'h7C);
    check("sll_wd", wd, 4);
    check("sll_wreg", wreg, 1);

    // Unsupported funct 101010
    pc = 32'h504; inst = 32'h0022182A;
    tick();
    check("bad_inval", inst_invalid, 1);
    check("bad_wreg", wreg, 0);
    check("bad_aluop", aluop, 0);
    check("bad_alusel", alusel, 0);
    check("bad_valid", valid, 1);
    check("bad_reg1", reg1, 0);

    // LUI $6,0x1234 reads $0: never forwarded, never a hazard
    pc = 32'h508; inst = 32'h3C061234;
    fwd_wreg = 2'b01; fwd_load = 2'b01; fwd_wd = {5'd0, 5'd0};
    fwd_wdata = {32'h0, 32'h00000077};
    #1;
    check("lui_ready", id_ready, 1);
    tick();
    check("lui_reg1", reg1, 0);
    check("lui_reg2", reg2, 32'h12340000);
    check("lui_wd", wd, 6);
    check("lui_inval", inst_invalid, 0);
    check("lui_cnt", stall_cnt, 3);

    // Asynchronous reset in the middle of a stall
    pc = 32'h600; inst = 32'h342200F0; fwd_wd = {5'd0, 5'd1};
    tick();
    check("rs_cnt_pre", stall_cnt, 4);
    check("rs_bubble", valid, 0);
    #2;
    rst = 1'b0;
    #1;
    check("rs_cnt", stall_cnt, 0);
    check("rs_valid", valid, 0);
    check("rs_pc", pc_q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
